// File: rtl/fifo_v3.sv
// fifo_v3: parameterised synchronous FIFO with optional fall-through and a
// zero-depth combinational pass-through mode.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);
  logic unused_testmode;
  assign unused_testmode = testmode_i;
  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk_i, rst_i, flush_i};
    assign data_o  = data_i;
    assign empty_o = ~push_i;
    assign full_o  = ~pop_i;
    assign usage_o = '0;
  end else begin : g_fifo
    localparam logic [ADDR_DEPTH-1:0] LAST = ADDR_DEPTH'(DEPTH - 1);
    logic [ADDR_DEPTH-1:0] read_ptr, write_ptr;
    logic [ADDR_DEPTH:0]   status_cnt;
    dtype                  mem [DEPTH];
    logic                  bypass, push, pop;
    // An empty fall-through FIFO hands the incoming word straight to the output.
    assign bypass  = FALL_THROUGH && status_cnt == '0 && push_i;
    assign full_o  = status_cnt == (ADDR_DEPTH+1)'(DEPTH);
    assign empty_o = status_cnt == '0 && !(FALL_THROUGH && push_i);
    assign usage_o = status_cnt[ADDR_DEPTH-1:0];
    assign data_o  = bypass ? data_i : mem[read_ptr];
    // A bypassed word that is popped in the same cycle never touches storage.
    assign push = push_i && !full_o && !(bypass && pop_i);
    assign pop  = pop_i && !empty_o && !bypass;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        read_ptr   <= '0;
        write_ptr  <= '0;
        status_cnt <= '0;
        mem        <= '{default: '0};
      end else if (flush_i) begin
        read_ptr   <= '0;
        write_ptr  <= '0;
        status_cnt <= '0;
      end else begin
        if (push) begin
          mem[write_ptr] <= data_i;
          write_ptr      <= (write_ptr == LAST) ? '0 : write_ptr + ADDR_DEPTH'(1);
        end
        if (pop) read_ptr <= (read_ptr == LAST) ? '0 : read_ptr + ADDR_DEPTH'(1);
        status_cnt <= status_cnt + (ADDR_DEPTH+1)'(push) - (ADDR_DEPTH+1)'(pop);
      end
    end
    push_full_warn: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
      else $warning("fifo_v3: push while full ignored");
    pop_empty_warn: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o))
      else $warning("fifo_v3: pop while empty ignored");
  end
endmodule

// File: tb/tb_fifo_v3.sv
// tb_fifo_v3: directed checks of fifo_v3 in normal, fall-through and pass-through builds.
module tb_fifo_v3;
  logic       clk = 1'b0;
  logic       rst, flush;
  logic [7:0] din;
  logic       push_a, pop_a, push_b, pop_b;
  logic       full_a, empty_a, full_b, empty_b, full_c, empty_c;
  logic [1:0] usage_a, usage_b;
  logic [0:0] usage_c;
  logic [7:0] dout_a, dout_b, dout_c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(1'b0),
    .full_o(full_a), .empty_o(empty_a), .usage_o(usage_a),
    .data_i(din), .push_i(push_a), .data_o(dout_a), .pop_i(pop_a));

  fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(1'b0),
    .full_o(full_b), .empty_o(empty_b), .usage_o(usage_b),
    .data_i(din), .push_i(push_b), .data_o(dout_b), .pop_i(pop_b));

  fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .testmode_i(1'b0),
    .full_o(full_c), .empty_o(empty_c), .usage_o(usage_c),
    .data_i(din), .push_i(push_a), .data_o(dout_c), .pop_i(pop_a));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; din = '0;
    push_a = 1'b0; pop_a = 1'b0; push_b = 1'b0; pop_b = 1'b0;
    #1;
    check("rst_empty_a", 32'(empty_a), 1);
    check("rst_full_a", 32'(full_a), 0);
    check("rst_usage_a", 32'(usage_a), 0);
    check("rst_data_a", 32'(dout_a), 0);
    check("rst_empty_b", 32'(empty_b), 1);
    tick;
    rst = 1'b0;
    // fill to full, no fall-through: data not visible on the push cycle
    push_a = 1'b1; din = 8'hA; #1;
    check("nft_empty_on_push", 32'(empty_a), 1);
    tick;
    check("nft_head_next", 32'(dout_a), 32'hA);
    din = 8'hB; tick;
    din = 8'hC; tick;
    din = 8'hD; tick;
    push_a = 1'b0;
    check("full_after4", 32'(full_a), 1);
    check("usage_wrap", 32'(usage_a), 0);
    pop_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("pop_order%0d", i), 32'(dout_a), 32'hA + i);
      tick;
    end
    check("empty_after_drain", 32'(empty_a), 1);
    check("usage_after_drain", 32'(usage_a), 0);
    tick;
    pop_a = 1'b0;
    check("pop_empty_stays", 32'(empty_a), 1);
    check("pop_empty_usage", 32'(usage_a), 0);
    // steady stream at two entries across pointer wrap
    push_a = 1'b1;
    din = 8'h10; tick;
    din = 8'h11; tick;
    pop_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = 8'h12 + 8'(i); #1;
      check($sformatf("stream_head%0d", i), 32'(dout_a), 32'h10 + i);
      tick;
      check($sformatf("stream_usage%0d", i), 32'(usage_a), 2);
    end
    pop_a = 1'b0;
    din = 8'h1C; tick;
    din = 8'h1D; tick;
    check("full_again", 32'(full_a), 1);
    // full + push + pop: push dropped, head popped
    din = 8'h0F; pop_a = 1'b1; #1;
    check("full_pp_head", 32'(dout_a), 32'h1A);
    tick;
    push_a = 1'b0;
    check("full_pp_usage", 32'(usage_a), 3);
    check("full_pp_notfull", 32'(full_a), 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("full_pp_order%0d", i), 32'(dout_a), 32'h1B + i);
      tick;
    end
    pop_a = 1'b0;
    check("full_pp_empty", 32'(empty_a), 1);
    // flush wins over push
    push_a = 1'b1;
    din = 8'h01; tick;
    din = 8'h02; tick;
    din = 8'h03; tick;
    check("pre_flush_usage", 32'(usage_a), 3);
    flush = 1'b1; din = 8'h77; tick;
    flush = 1'b0;
    push_a = 1'b0;
    check("flush_empty", 32'(empty_a), 1);
    check("flush_usage", 32'(usage_a), 0);
    push_a = 1'b1; din = 8'h42; tick;
    din = 8'h43; tick;
    push_a = 1'b0;
    check("post_flush_head", 32'(dout_a), 32'h42);
    check("post_flush_usage", 32'(usage_a), 2);
    // asynchronous reset between clock edges
    #2 rst = 1'b1; #1;
    check("arst_empty", 32'(empty_a), 1);
    check("arst_usage", 32'(usage_a), 0);
    check("arst_data", 32'(dout_a), 0);
    tick;
    rst = 1'b0;
    // fall-through: push+pop on empty bypasses storage
    push_b = 1'b1; pop_b = 1'b1; din = 8'h05; #1;
    check("ft_data", 32'(dout_b), 32'h05);
    check("ft_empty", 32'(empty_b), 0);
    tick;
    push_b = 1'b0; pop_b = 1'b0; #1;
    check("ft_bypass_usage", 32'(usage_b), 0);
    check("ft_bypass_empty", 32'(empty_b), 1);
    push_b = 1'b1; din = 8'h06; #1;
    check("ft_push_data", 32'(dout_b), 32'h06);
    tick;
    push_b = 1'b0; din = 8'h99; #1;
    check("ft_stored_usage", 32'(usage_b), 1);
    check("ft_stored_data", 32'(dout_b), 32'h06);
    // zero-depth pass-through
    push_a = 1'b1; pop_a = 1'b0; din = 8'h3C; #1;
    check("pt_data", 32'(dout_c), 32'h3C);
    check("pt_empty", 32'(empty_c), 0);
    check("pt_full", 32'(full_c), 1);
    check("pt_usage", 32'(usage_c), 0);
    pop_a = 1'b1; #1;
    check("pt_full_pop", 32'(full_c), 0);
    push_a = 1'b0; pop_a = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
